// File: rtl/lms_spi_arbiter.sv
// Round-robin arbiter sharing one LMS7002 SPI bus between N_REQ requesters.
// Each grant runs a single 32-bit mode-0 MSB-first transfer, then acks the winner.
module lms_spi_arbiter #(
  parameter int N_REQ   = 2,
  parameter int N_SS    = 5,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  cmd_word,
  input  logic [3*N_REQ-1:0]   cmd_ss,
  output logic [N_REQ-1:0]     ack,
  output logic                 err,
  output logic [15:0]          rdata,
  output logic                 busy,
  output logic                 spi_SCLK,
  output logic                 spi_MOSI,
  input  logic                 spi_MISO,
  output logic [N_SS-1:0]      spi_SS_n
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  state_t state, next_state;

  logic [DIV_W-1:0] div_cnt;
  logic             div_end;
  logic [5:0]       half_cnt;
  logic [2:0]       rr, win, next_rr, owner;
  logic             any_req, bad;
  logic [31:0]      sel_word;
  logic [2:0]       sel_ss;
  logic [30:0]      tx;
  logic [15:0]      rx;
  logic             rise_tick, fall_tick;

  assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall_tick = (state == SHIFT) && div_end && !half_cnt[0];
  assign rise_tick = div_end && ((state == SETUP) ||
                     ((state == SHIFT) && half_cnt[0] && (half_cnt != 6'd63)));

  // Later offsets are visited first so the nearest set request at/after rr wins.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (req[j] && (j == (int'(rr) + i) % N_REQ)) begin
          any_req = 1'b1;
          win     = 3'(j);
        end
      end
    end
  end

  always_comb begin
    sel_word = '0;
    sel_ss   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (win == 3'(j)) begin
        sel_word = cmd_word[32*j +: 32];
        sel_ss   = cmd_ss[3*j +: 3];
      end
    end
  end

  assign bad     = (int'(sel_ss) >= N_SS);
  assign next_rr = 3'((int'(win) + 1) % N_REQ);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = bad ? DONE : SETUP;
      SETUP:   if (div_end) next_state = SHIFT;
      SHIFT:   if (div_end && (half_cnt == 6'd63)) next_state = HOLD;
      HOLD:    if (div_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= next_state;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      spi_SS_n <= '1;
      spi_SCLK <= 1'b0;
      spi_MOSI <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      rr       <= '0;
      owner    <= '0;
      div_cnt  <= '0;
      half_cnt <= '0;
    end else begin
      ack     <= '0;
      err     <= 1'b0;
      div_cnt <= (state == IDLE || div_end) ? '0 : div_cnt + DIV_W'(1);
      case (state)
        IDLE: begin
          half_cnt <= '0;
          if (any_req) begin
            owner <= win;
            rr    <= next_rr;
            busy  <= 1'b1;
            if (bad) begin
              ack <= N_REQ'(1) << win;
              err <= 1'b1;
            end else begin
              spi_SS_n <= ~(N_SS'(1) << sel_ss);
              spi_MOSI <= sel_word[31];
            end
          end
        end
        SETUP: if (div_end) spi_SCLK <= 1'b1;
        SHIFT: begin
          if (div_end) half_cnt <= half_cnt + 6'd1;
          if (fall_tick) begin
            spi_SCLK <= 1'b0;
            spi_MOSI <= tx[30];
          end else if (rise_tick) begin
            spi_SCLK <= 1'b1;
          end
        end
        HOLD: begin
          if (div_end) begin
            spi_SS_n <= '1;
            ack      <= N_REQ'(1) << owner;
            rdata    <= rx;
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // Shift registers carry only data and need no reset; they are reloaded per grant.
  always_ff @(posedge clk_clk) begin
    if (state == IDLE && any_req) tx <= sel_word[30:0];
    else if (fall_tick)           tx <= {tx[29:0], 1'b0};
    if (rise_tick)                rx <= {rx[14:0], spi_MISO};
  end

endmodule
